cordic_rotvec: RTL and testbench

Parametrised, multi-mode successor to the fixed 24-bit sin/cos CORDIC. It is an iterative (one micro-rotation per clock) CORDIC engine supporting rotation mode (sin/cos, vector rotate) and vectoring mode (magnitude, atan2). It adds full-circle range extension, optional gain compensation, output saturation and a valid/ready handshake on both sides. It sits between the control/math sequencer and any consumer that needs trig, polar or rectangular conversion.

---
 rtl/cordic_rotvec.sv | 194 +++++++++++++++++++
 tb/tb_cordic_rotvec.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/cordic_rotvec.sv
// Iterative CORDIC engine: rotation (sin/cos, vector rotate) and vectoring (magnitude, atan2)
// with quadrant range extension, optional gain compensation, output saturation and valid/ready.
module cordic_rotvec #(
  parameter int WIDTH      = 24,
  parameter int FRAC       = 16,
  parameter int ITERATIONS = 16,
  parameter int GAIN_COMP  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    mode,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [WIDTH-1:0] z_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out,
  output logic signed [WIDTH-1:0] z_out
);

  localparam int IW  = WIDTH + 2;
  localparam int PW  = 2 * IW;
  localparam int RSH = 30 - FRAC;
  localparam logic [4:0] LAST = 5'(ITERATIONS - 1);

  typedef enum logic [2:0] {IDLE, PRE, ROT, COMP, DONE} state_t;

  state_t               state_q, state_d;
  logic [4:0]           iter;
  logic                 mode_r, zero_r;
  logic signed [IW-1:0] xr, yr, zr;
  logic signed [WIDTH-1:0] z_keep;

  // Round-half-up from Q2.30 to FRAC bits; the doubled form avoids a negative shift when RSH=0.
  function automatic logic signed [63:0] round_q30(input logic signed [63:0] c);
    return ((c <<< 1) + (64'sd1 <<< RSH)) >>> (RSH + 1);
  endfunction

  function automatic logic signed [63:0] atan_q30(input logic [4:0] idx);
    case (idx)
      5'd0:  return 64'sh3243F6A8;
      5'd1:  return 64'sh1DAC6705;
      5'd2:  return 64'sh0FADBAFC;
      5'd3:  return 64'sh07F56EA6;
      5'd4:  return 64'sh03FEAB76;
      5'd5:  return 64'sh01FFD55B;
      5'd6:  return 64'sh00FFFAAA;
      5'd7:  return 64'sh007FFF55;
      5'd8:  return 64'sh003FFFEA;
      5'd9:  return 64'sh001FFFFD;
      5'd10: return 64'sh000FFFFF;
      5'd11: return 64'sh0007FFFF;
      5'd12: return 64'sh0003FFFF;
      5'd13: return 64'sh0001FFFF;
      5'd14: return 64'sh0000FFFF;
      5'd15: return 64'sh00007FFF;
      5'd16: return 64'sh00003FFF;
      5'd17: return 64'sh00001FFF;
      5'd18: return 64'sh00000FFF;
      5'd19: return 64'sh000007FF;
      5'd20: return 64'sh000003FF;
      5'd21: return 64'sh000001FF;
      5'd22: return 64'sh000000FF;
      5'd23: return 64'sh0000007F;
      5'd24: return 64'sh0000003F;
      5'd25: return 64'sh0000001F;
      5'd26: return 64'sh0000000F;
      5'd27: return 64'sh00000008;
      5'd28: return 64'sh00000004;
      5'd29: return 64'sh00000002;
      default: return 64'sh0;
    endcase
  endfunction

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] hi, lo;
    hi = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    lo = ~hi;
    if (v > hi) return hi[WIDTH-1:0];
    if (v < lo) return lo[WIDTH-1:0];
    return v[WIDTH-1:0];
  endfunction

  logic signed [IW-1:0] pi_c, half_pi_c, k_c, atan_c, xs, ys;
  logic                 cw;
  logic signed [PW-1:0] xw, yw, zw, kw, xprod, yprod, xfin, yfin;

  assign pi_c      = IW'(round_q30(64'sh0C90FDAA2));
  assign half_pi_c = IW'(round_q30(64'sh06487ED51));
  assign k_c       = IW'(round_q30(64'sh026DD3B6A));
  assign atan_c    = IW'(round_q30(atan_q30(iter)));

  assign xs = xr >>> iter;
  assign ys = yr >>> iter;
  // cw: apply x -= y>>>i, y += x>>>i, z -= atan (rotation drives z to 0, vectoring drives y to 0)
  assign cw = mode_r ? yr[IW-1] : ~zr[IW-1];

  assign xw    = {{(PW-IW){xr[IW-1]}}, xr};
  assign yw    = {{(PW-IW){yr[IW-1]}}, yr};
  assign zw    = {{(PW-IW){zr[IW-1]}}, zr};
  assign kw    = {{(PW-IW){k_c[IW-1]}}, k_c};
  assign xprod = xw * kw;
  assign yprod = yw * kw;
  assign xfin  = (GAIN_COMP != 0) ? (xprod >>> FRAC) : xw;
  assign yfin  = (GAIN_COMP != 0) ? (yprod >>> FRAC) : yw;

  assign in_ready = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = PRE;
      PRE:     state_d = ROT;
      ROT:     if (iter == LAST) state_d = COMP;
      COMP:    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      iter      <= '0;
      out_valid <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      z_out     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ROT) iter <= iter + 5'd1;
      else if (state_q == IDLE) iter <= '0;
      if (state_q == COMP) begin
        out_valid <= 1'b1;
        x_out     <= zero_r ? '0 : sat(xfin);
        y_out     <= zero_r ? '0 : sat(yfin);
        z_out     <= zero_r ? z_keep : sat(zw);
      end else if (state_q == DONE && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Datapath: latch, range extension, micro-rotations
  always_ff @(posedge clk) begin
    case (state_q)
      IDLE: if (in_valid) begin
        xr     <= {{2{x_in[WIDTH-1]}}, x_in};
        yr     <= {{2{y_in[WIDTH-1]}}, y_in};
        zr     <= {{2{z_in[WIDTH-1]}}, z_in};
        z_keep <= z_in;
        mode_r <= mode;
        zero_r <= 1'b0;
      end
      PRE: begin
        if (!mode_r) begin
          if (zr > half_pi_c) begin
            xr <= -xr;
            yr <= -yr;
            zr <= zr - pi_c;
          end else if (zr < -half_pi_c) begin
            xr <= -xr;
            yr <= -yr;
            zr <= zr + pi_c;
          end
        end else begin
          zero_r <= (xr == '0) && (yr == '0);
          if (xr[IW-1]) begin
            xr <= -xr;
            yr <= -yr;
            zr <= yr[IW-1] ? (zr - pi_c) : (zr + pi_c);
          end
        end
      end
      ROT: begin
        if (cw) begin
          xr <= xr - ys;
          yr <= yr + xs;
          zr <= zr - atan_c;
        end else begin
          xr <= xr + ys;
          yr <= yr - xs;
          zr <= zr + atan_c;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cordic_rotvec.sv
// Scoreboard bench for cordic_rotvec: default instance plus a WIDTH=20 raw-gain instance.
module tb_cordic_rotvec;
  logic clk = 0, reset = 1;
  logic in_valid = 0, in_ready, mode = 0, out_valid, out_ready = 1;
  logic signed [23:0] x_in = 0, y_in = 0, z_in = 0, x_out, y_out, z_out;
  logic in_valid_s = 0, in_ready_s, mode_s = 0, out_valid_s, out_ready_s = 1;
  logic signed [19:0] xs_in = 0, ys_in = 0, zs_in = 0, xs_out, ys_out, zs_out;

  int checks = 0, failures = 0, cyc = 0, next_id = 0;
  typedef struct {int ex, ey, ez, tx, ty, tz, acc, id;} exp_t;
  exp_t q0[$], q1[$];
  exp_t e0, e1;
  bit pv0 = 0, pv1 = 0;

  cordic_rotvec dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .z_out(z_out));

  cordic_rotvec #(.WIDTH(20), .FRAC(16), .ITERATIONS(16), .GAIN_COMP(0)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid_s), .in_ready(in_ready_s), .mode(mode_s),
    .x_in(xs_in), .y_in(ys_in), .z_in(zs_in), .out_valid(out_valid_s), .out_ready(out_ready_s),
    .x_out(xs_out), .y_out(ys_out), .z_out(zs_out));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int req, int tol);
    int d;
    d = act - req;
    checks++;
    if (d > tol || -d > tol) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d tol=%0d", nm, act, req, tol);
    end
  endfunction

  always @(negedge clk) begin
    #1;
    if (!reset) begin
      if (out_valid && !pv0) begin
        if (q0.size() == 0) chk("unexpected_out", 1, 0, 0);
        else chk($sformatf("latency_%0d", q0[0].id), cyc - q0[0].acc, 18, 0);
      end
      if (out_valid && out_ready && q0.size() > 0) begin
        e0 = q0.pop_front();
        chk($sformatf("x_%0d", e0.id), int'(x_out), e0.ex, e0.tx);
        chk($sformatf("y_%0d", e0.id), int'(y_out), e0.ey, e0.ty);
        chk($sformatf("z_%0d", e0.id), int'(z_out), e0.ez, e0.tz);
      end
    end
    pv0 = out_valid;
  end

  always @(negedge clk) begin
    #1;
    if (!reset) begin
      if (out_valid_s && !pv1) begin
        if (q1.size() == 0) chk("unexpected_out_s", 1, 0, 0);
        else chk($sformatf("latency_%0d", q1[0].id), cyc - q1[0].acc, 18, 0);
      end
      if (out_valid_s && out_ready_s && q1.size() > 0) begin
        e1 = q1.pop_front();
        chk($sformatf("x_%0d", e1.id), int'(xs_out), e1.ex, e1.tx);
        chk($sformatf("y_%0d", e1.id), int'(ys_out), e1.ey, e1.ty);
        chk($sformatf("z_%0d", e1.id), int'(zs_out), e1.ez, e1.tz);
      end
    end
    pv1 = out_valid_s;
  end

  task automatic send(input bit s, input bit m, input int x, input int y, input int z,
                      input int ex, input int ey, input int ez,
                      input int tx, input int ty, input int tz, input bit push, output int acc);
    exp_t e;
    @(negedge clk);
    if (s) begin
      mode_s = m; xs_in = x[19:0]; ys_in = y[19:0]; zs_in = z[19:0]; in_valid_s = 1;
    end else begin
      mode = m; x_in = x[23:0]; y_in = y[23:0]; z_in = z[23:0]; in_valid = 1;
    end
    acc = -1;
    for (int k = 0; k < 200; k++) begin
      if (s ? in_ready_s : in_ready) begin
        acc = cyc + 1;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) chk("accept_timeout", 1, 0, 0);
    else if (push) begin
      e = '{ex, ey, ez, tx, ty, tz, acc, next_id};
      next_id++;
      if (s) q1.push_back(e); else q0.push_back(e);
    end
    @(negedge clk);
    in_valid = 0;
    in_valid_s = 0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 400; k++) begin
      if (q0.size() == 0 && q1.size() == 0 && in_ready && in_ready_s) return;
      @(negedge clk);
    end
    chk("drain_timeout", 1, 0, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, acc;
    int sx, sy, sz;
    repeat (3) @(negedge clk);
    reset = 0;
    chk("rst_out_valid", int'(out_valid), 0, 0);
    chk("rst_x_out", int'(x_out), 0, 0);
    chk("rst_y_out", int'(y_out), 0, 0);
    chk("rst_z_out", int'(z_out), 0, 0);
    chk("rst_in_ready", int'(in_ready), 1, 0);
    chk("rst_out_valid_s", int'(out_valid_s), 0, 0);

    // rotation: pi/4, pi, -pi/2 back to back
    send(0, 0, 65536, 0, 51472, 46341, 46341, 0, 4, 4, 8, 1, a1);
    send(0, 0, 65536, 0, 205887, -65536, 0, 0, 4, 4, 8, 1, a2);
    chk("throughput", a2 - a1, 20, 0);
    send(0, 0, 65536, 0, -102943, 0, -65536, 0, 4, 4, 8, 1, acc);
    // vectoring: (3,4), (-1,0), (0,0)
    send(0, 1, 196608, 262144, 0, 327680, 0, 60771, 4, 4, 4, 1, acc);
    send(0, 1, -65536, 0, 0, 65536, 0, 205887, 4, 4, 4, 1, acc);
    send(0, 1, 0, 0, 4660, 0, 0, 4660, 0, 0, 0, 1, acc);
    wait_done();

    // backpressure
    out_ready = 0;
    send(0, 0, 65536, 0, 0, 65536, 0, 0, 4, 4, 8, 1, acc);
    for (int k = 0; k < 100 && !out_valid; k++) @(negedge clk);
    sx = int'(x_out); sy = int'(y_out); sz = int'(z_out);
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid_held", int'(out_valid), 1, 0);
      chk("bp_in_ready_low", int'(in_ready), 0, 0);
      chk("bp_x_stable", int'(x_out), sx, 0);
      chk("bp_y_stable", int'(y_out), sy, 0);
      chk("bp_z_stable", int'(z_out), sz, 0);
      if (c == 3 || c == 6) begin
        in_valid = 1; x_in = 24'sh123456; z_in = 24'sh001000;
      end else in_valid = 0;
      @(negedge clk);
    end
    in_valid = 0;
    out_ready = 1;
    chk("bp_in_ready_before", int'(in_ready), 0, 0);
    @(negedge clk);
    chk("bp_valid_fall", int'(out_valid), 0, 0);
    chk("bp_in_ready_rise", int'(in_ready), 1, 0);
    repeat (25) @(negedge clk);
    chk("bp_no_spurious", int'(out_valid), 0, 0);

    // reset in the middle of ROT
    send(0, 0, 65536, 0, 51472, 0, 0, 0, 0, 0, 0, 0, acc);
    while (cyc < acc + 7) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("midrst_out_valid", int'(out_valid), 0, 0);
    chk("midrst_x_out", int'(x_out), 0, 0);
    chk("midrst_y_out", int'(y_out), 0, 0);
    chk("midrst_z_out", int'(z_out), 0, 0);
    chk("midrst_in_ready", int'(in_ready), 1, 0);
    send(0, 0, 65536, 0, 51472, 46341, 46341, 0, 4, 4, 8, 1, acc);
    wait_done();

    // raw gain and saturation on the 20-bit instance
    send(1, 0, 524287, 0, 0, 524287, 0, 0, 0, 64, 8, 1, acc);
    send(1, 0, 65536, 0, 0, 107922, 0, 0, 4, 8, 8, 1, acc);
    wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
